fifo_push_arbiter: RTL and testbench

//   Round-robin arbiter that shares the write port of one FIFO among drvrs requesters.

---
 rtl/fifo_push_arbiter_if.sv | 39 +++
 rtl/fifo_push_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_push_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fifo_push_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_push_arbiter_if
// Description : Bundles the request side and the FIFO side of the push
//               arbiter into one bus.
//               master : requesters / FIFO model (drives en, req, data_in,
//                        fifo_count; observes push, data_out, ack, grant_id,
//                        full_stall)
//               slave  : the arbiter itself
// Ports       : en, req[DRVRS], data_in[DRVRS*PCKG_SZ], fifo_count,
//               push, data_out[PCKG_SZ], ack[DRVRS], grant_id, full_stall
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_push_arbiter_if #(
    parameter int DRVRS   = 4,
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 16
);
    logic                       en;
    logic [DRVRS-1:0]           req;
    logic [DRVRS*PCKG_SZ-1:0]   data_in;
    logic [$clog2(DEPTH):0]     fifo_count;
    logic                       push;
    logic [PCKG_SZ-1:0]         data_out;
    logic [DRVRS-1:0]           ack;
    logic [$clog2(DRVRS)-1:0]   grant_id;
    logic                       full_stall;

    modport master (
        output en, req, data_in, fifo_count,
        input  push, data_out, ack, grant_id, full_stall
    );

    modport slave (
        input  en, req, data_in, fifo_count,
        output push, data_out, ack, grant_id, full_stall
    );
endinterface
`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_push_arbiter
// Description : Round-robin arbiter sharing one FIFO write port among DRVRS
//               requesters. A grant is taken in IDLE when enabled, something
//               is requested and the FIFO reports space; the winner's word is
//               registered and pushed for exactly one cycle (PUSH state), so
//               at most one push every two cycles and the FIFO count is
//               always up to date when the next decision is made.
// Ports       : clk_i      - clock, rising edge
//               rst_i      - asynchronous reset, active-low
//               bus        - slave side of fifo_push_arbiter_if
//                            (en, req, data_in, fifo_count in;
//                             push, data_out, ack, grant_id, full_stall out)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_push_arbiter #(
    parameter int DRVRS   = 4,
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 16
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    fifo_push_arbiter_if.slave   bus
);

    localparam int ID_W  = $clog2(DRVRS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);
    localparam logic [ID_W-1:0]  C_PTR_INIT = ID_W'(DRVRS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PUSH = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 push_q, push_d;
    logic [DRVRS-1:0]     ack_q, ack_d;
    logic [PCKG_SZ-1:0]   data_out_q, data_out_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic                 full_stall_q, full_stall_d;

    logic                 w_space;
    logic                 w_found;
    logic [ID_W-1:0]      w_win;
    logic [ID_W-1:0]      w_idx;

    // Counts beyond DEPTH are treated as full as well.
    assign w_space = (bus.fifo_count < C_DEPTH);

    // Round-robin search starting one past the last winner, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = ptr_q;
        w_idx   = ptr_q;
        for (int k = 1; k <= DRVRS; k++) begin
            w_idx = ID_W'((int'(ptr_q) + k) % DRVRS);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        push_d       = 1'b0;
        ack_d        = '0;
        data_out_d   = data_out_q;
        grant_id_d   = grant_id_q;
        ptr_d        = ptr_q;
        full_stall_d = (|bus.req) & ~w_space;

        case (state_q)
            IDLE: begin
                if (bus.en && w_found && w_space) begin
                    push_d        = 1'b1;
                    ack_d[w_win]  = 1'b1;
                    data_out_d    = bus.data_in[int'(w_win)*PCKG_SZ +: PCKG_SZ];
                    grant_id_d    = w_win;
                    ptr_d         = w_win;
                    state_d       = PUSH;
                end
            end
            // The push in flight always completes, regardless of en.
            PUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            push_q       <= 1'b0;
            ack_q        <= '0;
            data_out_q   <= '0;
            grant_id_q   <= '0;
            ptr_q        <= C_PTR_INIT;
            full_stall_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            push_q       <= push_d;
            ack_q        <= ack_d;
            data_out_q   <= data_out_d;
            grant_id_q   <= grant_id_d;
            ptr_q        <= ptr_d;
            full_stall_q <= full_stall_d;
        end
    end

    assign bus.push       = push_q;
    assign bus.ack        = ack_q;
    assign bus.data_out   = data_out_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.full_stall = full_stall_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_push_arbiter
// Description : Directed self-checking bench for fifo_push_arbiter
//               (DRVRS=4, PCKG_SZ=16, DEPTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_push_arbiter;

    localparam int DRVRS   = 4;
    localparam int PCKG_SZ = 16;
    localparam int DEPTH   = 16;

    logic clk;
    logic rst_n;
    int   n_asserts;
    int   n_fails;

    fifo_push_arbiter_if #(.DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH)) bus ();

    fifo_push_arbiter #(.DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_push"},       64'(bus.push),       64'd0);
        check({tag, "_ack"},        64'(bus.ack),        64'd0);
        check({tag, "_data_out"},   64'(bus.data_out),   64'd0);
        check({tag, "_grant_id"},   64'(bus.grant_id),   64'd0);
        check({tag, "_full_stall"}, 64'(bus.full_stall), 64'd0);
    endtask

    initial begin
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        n_asserts = 0;
        n_fails   = 0;

        // ---- 1: reset state, inputs already requesting ----
        rst_n          = 1'b0;
        bus.en         = 1'b1;
        bus.req        = 4'b1111;
        bus.fifo_count = 5'd16;
        for (int i = 0; i < DRVRS; i++) bus.data_in[i*PCKG_SZ +: PCKG_SZ] = 16'h1000 + 16'(i);
        tick();
        tick();
        check_zero("reset");

        bus.req        = 4'b0000;
        bus.fifo_count = 5'd0;
        #2 rst_n = 1'b1;
        tick();
        check("idle_push", 64'(bus.push), 64'd0);

        // ---- 2: single request on port 2 ----
        bus.req = 4'b0100;
        bus.data_in[2*PCKG_SZ +: PCKG_SZ] = 16'hA5A5;
        tick();
        check("t2_push",     64'(bus.push),     64'd1);
        check("t2_ack",      64'(bus.ack),      64'b0100);
        check("t2_data_out", 64'(bus.data_out), 64'hA5A5);
        check("t2_grant_id", 64'(bus.grant_id), 64'd2);
        bus.req = 4'b0000;
        tick();
        check("t2_push_end", 64'(bus.push),     64'd0);
        check("t2_ack_end",  64'(bus.ack),      64'd0);
        check("t2_data_hold",64'(bus.data_out), 64'hA5A5);

        // ---- 3: all ports requesting from fresh reset -> 0,1,2,3,0 ----
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < DRVRS; i++) bus.data_in[i*PCKG_SZ +: PCKG_SZ] = 16'hB000 + 16'(i);
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_push",     64'(bus.push),     64'd1);
            check("t3_grant_id", 64'(bus.grant_id), 64'(exp_seq[i]));
            check("t3_ack",      64'(bus.ack),      64'(4'b0001 << exp_seq[i]));
            check("t3_data_out", 64'(bus.data_out), 64'(16'hB000 + 16'(exp_seq[i])));
            tick();
            check("t3_gap",      64'(bus.push),     64'd0);
        end

        // ---- 4: full FIFO stalls, then space opens ----
        bus.req        = 4'b0001;
        bus.fifo_count = 5'd16;
        tick();
        check("t4_full_push",  64'(bus.push),       64'd0);
        check("t4_full_stall", 64'(bus.full_stall), 64'd1);
        bus.fifo_count = 5'd20;
        tick();
        check("t4_over_push",  64'(bus.push),       64'd0);
        check("t4_over_stall", 64'(bus.full_stall), 64'd1);
        bus.fifo_count = 5'd15;
        tick();
        check("t4_push",       64'(bus.push),       64'd1);
        check("t4_ack",        64'(bus.ack),        64'b0001);
        check("t4_stall_clr",  64'(bus.full_stall), 64'd0);
        bus.req = 4'b0000;
        bus.fifo_count = 5'd0;
        tick();
        check("t4_push_end",   64'(bus.push),       64'd0);

        // ---- 5: en dropped during PUSH of port 1 ----
        bus.req = 4'b0010;
        tick();
        check("t5_grant_id", 64'(bus.grant_id), 64'd1);
        check("t5_push",     64'(bus.push),     64'd1);
        bus.en  = 1'b0;
        bus.req = 4'b1111;
        tick();
        check("t5_complete", 64'(bus.push), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_blocked", 64'(bus.push), 64'd0);
        end
        bus.en = 1'b1;
        tick();
        check("t5_resume_push", 64'(bus.push),     64'd1);
        check("t5_resume_id",   64'(bus.grant_id), 64'd2);
        tick();
        check("t5_resume_end",  64'(bus.push),     64'd0);

        // ---- 6: async reset while pushing port 3 ----
        tick();
        check("t6_push",     64'(bus.push),     64'd1);
        check("t6_grant_id", 64'(bus.grant_id), 64'd3);
        check("t6_data_out", 64'(bus.data_out), 64'hB003);
        #1 rst_n = 1'b0;
        #1;
        check_zero("t6_async");
        #3 rst_n = 1'b1;
        tick();
        check("t6_after_push", 64'(bus.push),     64'd1);
        check("t6_after_id",   64'(bus.grant_id), 64'd0);
        check("t6_after_ack",  64'(bus.ack),      64'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
